// File: rtl/pwm_demod_pkg.sv
// pwm_demod_pkg: shared FSM state type and frame constants for the PWM demodulator
package pwm_demod_pkg;
    localparam int DEF_WIDTH  = 8;
    localparam int FRAME_LEN  = 1 << DEF_WIDTH;
    localparam int SAMPLE_MAX = FRAME_LEN - 1;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/pwm_win_stats.sv
// pwm_win_stats: running min/max over a window of samples, publishing min/max/pp per window
module pwm_win_stats
    import pwm_demod_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WIN_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] win_max_o,
    output logic [WIDTH-1:0] win_min_o,
    output logic [WIDTH-1:0] win_pp_o,
    output logic             stats_valid_o
);
    localparam int CW = $clog2(WIN_FRAMES);
    logic [CW-1:0] cnt_q;
    logic [WIDTH-1:0] max_q, min_q, max_n, min_n;
    logic first, last;
    assign first = (cnt_q == '0);
    assign last  = (cnt_q == CW'(WIN_FRAMES - 1));
    assign max_n = (first || sample_i > max_q) ? sample_i : max_q;
    assign min_n = (first || sample_i < min_q) ? sample_i : min_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            max_q         <= '0;
            min_q         <= '0;
            win_max_o     <= '0;
            win_min_o     <= '0;
            win_pp_o      <= '0;
            stats_valid_o <= 1'b0;
        end else begin
            stats_valid_o <= valid_i & last & ~clr_i;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (valid_i) begin
                max_q <= max_n;
                min_q <= min_n;
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    win_max_o <= max_n;
                    win_min_o <= min_n;
                    win_pp_o  <= max_n - min_n;
                end
            end
        end
    end
endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: recovers one sample per PWM frame by counting high cycles, with windowed statistics
module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int WIN_FRAMES  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    output logic             locked,
    output logic             lock_lost,
    output logic [WIDTH-1:0] win_max,
    output logic [WIDTH-1:0] win_min,
    output logic [WIDTH-1:0] win_pp,
    output logic             stats_valid
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q, mis_q, sample_valid_q, lock_lost_q;
    state_e state_q;
    logic [WIDTH-1:0] pos_q, sample_q, sample_d;
    logic [WIDTH:0] hc_q, hc_tot;
    logic pwm_s, rise, frame_end, mis_now, emit, drop;

    assign pwm_s     = sync_q[SYNC_STAGES-1];
    assign rise      = pwm_s & ~prev_q;
    assign hc_tot    = hc_q + {{WIDTH{1'b0}}, pwm_s};
    assign frame_end = (state_q == RUN) && (pos_q == '1);
    assign mis_now   = mis_q | (rise && pos_q != '0);
    assign emit      = frame_end & ~mis_now;
    assign drop      = frame_end & mis_now;
    // an all-high frame counts 2^WIDTH and saturates to the top code
    assign sample_d  = emit ? (hc_tot[WIDTH] ? {WIDTH{1'b1}} : hc_tot[WIDTH-1:0]) : sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '0;
            prev_q         <= 1'b0;
            state_q        <= IDLE;
            pos_q          <= '0;
            hc_q           <= '0;
            mis_q          <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            lock_lost_q    <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q         <= pwm_s;
            sample_q       <= sample_d;
            sample_valid_q <= emit;
            lock_lost_q    <= drop;
            if (state_q == IDLE) begin
                if (rise) begin
                    state_q <= RUN;
                    pos_q   <= WIDTH'(1);
                    hc_q    <= (WIDTH + 1)'(1);
                    mis_q   <= 1'b0;
                end
            end else begin
                pos_q <= pos_q + 1'b1;
                hc_q  <= frame_end ? '0 : hc_tot;
                mis_q <= frame_end ? 1'b0 : mis_now;
                if (drop) state_q <= IDLE;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign lock_lost    = lock_lost_q;
    assign locked       = (state_q == RUN);

    pwm_win_stats #(.WIDTH(WIDTH), .WIN_FRAMES(WIN_FRAMES)) u_stats (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (drop),
        .sample_i      (sample_d),
        .valid_i       (emit),
        .win_max_o     (win_max),
        .win_min_o     (win_min),
        .win_pp_o      (win_pp),
        .stats_valid_o (stats_valid)
    );
endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: table, hand-written and randomized frame stimulus against a frame-level reference model
module tb_pwm_demod;
    import pwm_demod_pkg::*;
    localparam int W = 8;
    localparam int S = 2;
    localparam int WIN = 64;

    typedef struct {int duty; int exp_sample;} vec_t;
    typedef struct {int mx; int mn; int pp;} st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    logic [W-1:0] sample, win_max, win_min, win_pp;
    logic sample_valid, locked, lock_lost, stats_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    int win_buf[$];
    st_t stats_q[$];
    st_t st_hist[$];
    int vcyc[$];
    int n_lost = 0;
    int lost_locked = 1;
    int lock_watch = 0;
    int lock_drops = 0;
    int last_bit_cyc, frame_start_cyc;

    pwm_demod #(.WIDTH(W), .SYNC_STAGES(S), .WIN_FRAMES(WIN)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in),
        .sample(sample), .sample_valid(sample_valid),
        .locked(locked), .lock_lost(lock_lost),
        .win_max(win_max), .win_min(win_min), .win_pp(win_pp),
        .stats_valid(stats_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_sample(input int d);
        return (d > FRAME_LEN - 1) ? FRAME_LEN - 1 : d;
    endfunction

    // A good frame contributes one sample; a full window yields its extremes
    task automatic model_push(input int s);
        st_t st;
        exp_q.push_back(s);
        win_buf.push_back(s);
        if (win_buf.size() == WIN) begin
            st.mx = 0;
            st.mn = FRAME_LEN;
            foreach (win_buf[i]) begin
                if (win_buf[i] > st.mx) st.mx = win_buf[i];
                if (win_buf[i] < st.mn) st.mn = win_buf[i];
            end
            st.pp = st.mx - st.mn;
            stats_q.push_back(st);
            win_buf.delete();
        end
    endtask

    task automatic drive_frame(input int d, input int glitch, input int exp_s);
        for (int p = 0; p < FRAME_LEN; p++) begin
            @(negedge clk);
            if (p == 0) frame_start_cyc = cyc;
            if (p == FRAME_LEN - 1) last_bit_cyc = cyc;
            pwm_in = (p < d) || (glitch > 0 && p >= glitch && p < glitch + 8);
        end
        if (glitch > 0) win_buf.delete();
        else model_push(exp_s);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sample"}, sample, 0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        check({tag, "_win_max"}, win_max, 0);
        check({tag, "_win_min"}, win_min, 0);
        check({tag, "_win_pp"}, win_pp, 0);
        check({tag, "_stats_valid"}, stats_valid, 0);
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            check("valid_has_expect", int'(exp_q.size() != 0), 1);
            check("locked_at_valid", locked, 1);
            if (exp_q.size() != 0) check("sample", sample, exp_q.pop_front());
            vcyc.push_back(cyc);
        end
        if (stats_valid) begin
            st_t e, g;
            g.mx = win_max; g.mn = win_min; g.pp = win_pp;
            st_hist.push_back(g);
            check("stats_with_sample_valid", sample_valid, 1);
            check("stats_has_expect", int'(stats_q.size() != 0), 1);
            if (stats_q.size() != 0) begin
                e = stats_q.pop_front();
                check("win_max", g.mx, e.mx);
                check("win_min", g.mn, e.mn);
                check("win_pp", g.pp, e.pp);
            end
        end
        if (lock_lost) begin
            n_lost++;
            lost_locked = locked;
        end
        if (lock_watch != 0 && !locked) lock_drops++;
    end

    initial begin
        vec_t tbl[6];
        int rise_cyc, lb1, nv, ph, dr;
        tbl[0] = '{0, 0};
        tbl[1] = '{1, 1};
        tbl[2] = '{255, 255};
        tbl[3] = '{256, 255};
        tbl[4] = '{37, 37};
        tbl[5] = '{128, 128};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_zero_duty_locked", locked, 0);
        check("idle_zero_duty_valids", vcyc.size(), 0);

        drive_frame(128, 0, 128);
        rise_cyc = frame_start_cyc;
        lb1 = last_bit_cyc;
        check("locked_after_rise", locked, 1);
        lock_watch = 1;
        for (int f = 0; f < 3; f++) drive_frame(128, 0, 128);
        foreach (tbl[i]) drive_frame(tbl[i].duty, 0, tbl[i].exp_sample);
        check("first_valid_from_rise", vcyc[0] - rise_cyc, FRAME_LEN - 1 + S + 1);
        check("last_bit_latency", vcyc[0] - lb1, S + 1);
        check("valid_period", vcyc[3] - vcyc[2], FRAME_LEN);
        check("lock_held", lock_drops, 0);
        lock_watch = 0;

        drive_frame(50, 100, 0);
        for (int k = 0; k < 64; k++) drive_frame(10 + k, 0, 10 + k);
        check("lock_lost_count", n_lost, 1);
        check("locked_at_lock_lost", lost_locked, 0);
        check("relocked", locked, 1);
        for (int k = 0; k < 64; k++) drive_frame(200, 0, 200);
        for (int k = 0; k < 5; k++) begin
            dr = $urandom_range(0, FRAME_LEN);
            drive_frame(dr, 0, ref_sample(dr));
        end
        check("stats_windows_so_far", st_hist.size(), 2);
        check("ramp_win_min", st_hist[0].mn, 10);
        check("ramp_win_max", st_hist[0].mx, 73);
        check("ramp_win_pp", st_hist[0].pp, 63);
        check("const_win_pp", st_hist[1].pp, 0);
        check("const_win_max", st_hist[1].mx, 200);

        dr = $urandom_range(1, FRAME_LEN);
        for (int p = 0; p < 77; p++) begin
            @(negedge clk);
            pwm_in = (p < dr);
        end
        @(negedge clk);
        check("pending_before_reset", exp_q.size(), 0);
        rst = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_reset");
        rst = 1'b0;
        exp_q.delete();
        win_buf.delete();
        nv = vcyc.size();
        repeat (50) @(negedge clk);
        check("post_reset_locked", locked, 0);
        check("post_reset_no_sample", vcyc.size() - nv, 0);

        ph = $urandom_range(1, 31);
        for (int a = 1; a <= 3; a++) begin
            for (int k = 0; k < 64; k++) begin
                int i, base, d;
                i = (k + ph) % 64;
                base = (i < 32) ? i * 8 : (63 - i) * 8;
                d = base >> (3 - a);
                drive_frame(d, 0, ref_sample(d));
            end
        end
        pwm_in = 1'b0;
        repeat (S + 4) @(negedge clk);
        check("stats_windows_total", st_hist.size(), 5);
        check("amp1_pp", st_hist[2].pp, 62);
        check("amp2_pp", st_hist[3].pp, 124);
        check("amp3_pp", st_hist[4].pp, 248);
        check("pp_monotonic", int'(st_hist[2].pp < st_hist[3].pp && st_hist[3].pp < st_hist[4].pp), 1);
        check("samples_drained", exp_q.size(), 0);
        check("stats_drained", stats_q.size(), 0);
        check("lock_lost_total", n_lost, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
